// File: rtl/prog_loader_if.sv
// Byte-stream handshake between a byte source (UART RX / host bridge) and the program loader.
interface prog_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses A5/LEN/data/CHK frames into a 16x8 instruction memory and gates cpu_run.
// Optional idle-timeout inside a frame is enabled with `define LOADER_TIMEOUT_EN.
module prog_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic              CLK,
    input  logic              RST_N,
    prog_loader_if.slave      bus,
    input  logic [3:0]        cpu_addr,
    output logic [7:0]        cpu_instr,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err,
    output logic [4:0]        prog_len
);

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_LEN  = 2'd1,
        S_DATA = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // The idle counter is 21 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 2097151) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..2097151");
    end

    state_t     state;
    logic       rdy;
    logic [3:0] idx;
    logic [7:0] sum;
    logic [4:0] len_n;
    logic       accept;
    logic [7:0] chk_total;
    logic [7:0] mem [16];

    assign bus.in_ready = rdy;
    assign accept       = bus.in_valid && rdy;
    assign chk_total    = sum + bus.in_data;
    assign cpu_instr    = mem[cpu_addr];

    // Memory is never reset or cleared; only DATA bytes are written.
    always_ff @(posedge CLK) begin
        if (accept && state == S_DATA) begin
            mem[idx] <= bus.in_data;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    localparam logic [20:0] IDLE_LAST = 21'(TIMEOUT_CYCLES - 1);
    logic [20:0] idle_cnt;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_SYNC;
            rdy       <= 1'b0;
            cpu_run   <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            prog_len  <= 5'd0;
            idx       <= 4'd0;
            sum       <= 8'd0;
            len_n     <= 5'd0;
`ifdef LOADER_TIMEOUT_EN
            idle_cnt  <= 21'd0;
`endif
        end else begin
            rdy       <= 1'b1;
            load_done <= 1'b0;
            case (state)
                S_SYNC: begin
                    if (accept && bus.in_data == SYNC_BYTE) begin
                        state    <= S_LEN;
                        cpu_run  <= 1'b0;
                        load_err <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (bus.in_data != 8'd0 && bus.in_data <= 8'd16) begin
                            len_n <= bus.in_data[4:0];
                            idx   <= 4'd0;
                            sum   <= 8'd0;
                            state <= S_DATA;
                        end else begin
                            load_err <= 1'b1;
                            state    <= S_SYNC;
                        end
                    end
                end
                S_DATA: begin
                    // A5 here is plain data; no resync inside a frame.
                    if (accept) begin
                        sum <= chk_total;
                        idx <= idx + 4'd1;
                        if ({1'b0, idx} == len_n - 5'd1) begin
                            state <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        if (chk_total == 8'd0) begin
                            cpu_run   <= 1'b1;
                            prog_len  <= len_n;
                            load_done <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                        end
                        state <= S_SYNC;
                    end
                end
                default: state <= S_SYNC;
            endcase
`ifdef LOADER_TIMEOUT_EN
            // Placed after the case so an expiry overrides the stalled state.
            if (state == S_SYNC || accept) begin
                idle_cnt <= 21'd0;
            end else if (idle_cnt == IDLE_LAST) begin
                idle_cnt <= 21'd0;
                load_err <= 1'b1;
                state    <= S_SYNC;
            end else begin
                idle_cnt <= idle_cnt + 21'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad frames, bad length, A5-as-data, halt, reset and timeout.
module tb_prog_loader;

    logic       CLK;
    logic       RST_N;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_instr;
    logic       cpu_run;
    logic       load_done;
    logic       load_err;
    logic [4:0] prog_len;

    int tests;
    int fails;

    prog_loader_if bus ();

    prog_loader #(.TIMEOUT_CYCLES(16)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bus       (bus),
        .cpu_addr  (cpu_addr),
        .cpu_instr (cpu_instr),
        .cpu_run   (cpu_run),
        .load_done (load_done),
        .load_err  (load_err),
        .prog_len  (prog_len)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One byte per call; back-to-back calls give one accepted byte per cycle.
    task automatic send(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic read_mem(input string tag, input logic [3:0] a, input logic [7:0] exp);
        cpu_addr = a;
        #1;
        check(tag, {24'd0, cpu_instr}, {24'd0, exp});
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        RST_N        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        cpu_addr     = 4'd0;

        // Reset values
        repeat (2) @(posedge CLK);
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
        check("rst_prog_len", {27'd0, prog_len}, 32'd0);
        RST_N = 1'b1;
        idle(1);
        check("ready_after_release", {31'd0, bus.in_ready}, 32'd1);

        // Good load: A5 03 11 22 33 9A
        send(8'hA5);
        send(8'h03);
        cpu_addr = 4'd0;
        send(8'h11);
        check("wr_to_rd_latency", {24'd0, cpu_instr}, 32'h11);
        send(8'h22);
        send(8'h33);
        check("good_no_done_early", {31'd0, load_done}, 32'd0);
        send(8'h9A);
        check("good_load_done", {31'd0, load_done}, 32'd1);
        check("good_cpu_run", {31'd0, cpu_run}, 32'd1);
        check("good_prog_len", {27'd0, prog_len}, 32'd3);
        check("good_load_err", {31'd0, load_err}, 32'd0);
        idle(1);
        check("good_done_one_cycle", {31'd0, load_done}, 32'd0);
        read_mem("good_mem0", 4'd0, 8'h11);
        read_mem("good_mem1", 4'd1, 8'h22);
        read_mem("good_mem2", 4'd2, 8'h33);

        // Bad checksum: A5 02 10 20 00
        send(8'hA5);
        check("sync_clears_run", {31'd0, cpu_run}, 32'd0);
        send(8'h02);
        send(8'h10);
        send(8'h20);
        send(8'h00);
        check("badchk_err", {31'd0, load_err}, 32'd1);
        check("badchk_run", {31'd0, cpu_run}, 32'd0);
        check("badchk_no_done", {31'd0, load_done}, 32'd0);
        check("badchk_len_kept", {27'd0, prog_len}, 32'd3);
        read_mem("badchk_mem0", 4'd0, 8'h10);
        read_mem("badchk_mem1", 4'd1, 8'h20);
        read_mem("badchk_mem2_kept", 4'd2, 8'h33);

        // Bad length: A5 00, then A5 11, then a good frame A5 01 7F 81
        send(8'hA5);
        check("sync_clears_err", {31'd0, load_err}, 32'd0);
        send(8'h00);
        check("len0_err", {31'd0, load_err}, 32'd1);
        send(8'hA5);
        send(8'h11);
        check("len17_err", {31'd0, load_err}, 32'd1);
        send(8'hA5);
        send(8'h01);
        send(8'h7F);
        send(8'h81);
        check("after_badlen_done", {31'd0, load_done}, 32'd1);
        check("after_badlen_err", {31'd0, load_err}, 32'd0);
        check("after_badlen_run", {31'd0, cpu_run}, 32'd1);
        check("after_badlen_len", {27'd0, prog_len}, 32'd1);
        read_mem("after_badlen_mem0", 4'd0, 8'h7F);

        // A5 as data, stray bytes while running, then halt on new sync
        send(8'hA5);
        send(8'h02);
        send(8'hA5);
        send(8'h5B);
        send(8'h00);
        check("a5data_run", {31'd0, cpu_run}, 32'd1);
        check("a5data_len", {27'd0, prog_len}, 32'd2);
        read_mem("a5data_mem0", 4'd0, 8'hA5);
        read_mem("a5data_mem1", 4'd1, 8'h5B);
        send(8'h00);
        send(8'h00);
        check("stray_run_kept", {31'd0, cpu_run}, 32'd1);
        check("stray_no_done", {31'd0, load_done}, 32'd0);
        send(8'hA5);
        check("halt_on_sync", {31'd0, cpu_run}, 32'd0);

        // Reset mid-frame (already in LEN): 04 11 then reset
        send(8'h04);
        send(8'h11);
        RST_N = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("midrst_prog_len", {27'd0, prog_len}, 32'd0);
        check("midrst_cpu_run", {31'd0, cpu_run}, 32'd0);
        check("midrst_load_err", {31'd0, load_err}, 32'd0);
        read_mem("midrst_mem0_kept", 4'd0, 8'h11);
        idle(2);
        RST_N = 1'b1;
        idle(1);
        send(8'hA5);
        send(8'h02);
        send(8'h01);
        send(8'h02);
        send(8'hFD);
        check("postrst_done", {31'd0, load_done}, 32'd1);
        check("postrst_run", {31'd0, cpu_run}, 32'd1);
        check("postrst_len", {27'd0, prog_len}, 32'd2);
        read_mem("postrst_mem1", 4'd1, 8'h02);

`ifdef LOADER_TIMEOUT_EN
        // Timeout with TIMEOUT_CYCLES=16: A5 02 11 then 16 idle cycles
        send(8'hA5);
        send(8'h02);
        send(8'h11);
        idle(15);
        check("timeout_not_yet", {31'd0, load_err}, 32'd0);
        idle(1);
        check("timeout_err", {31'd0, load_err}, 32'd1);
        check("timeout_run", {31'd0, cpu_run}, 32'd0);
        send(8'hA5);
        send(8'h01);
        send(8'h10);
        send(8'hF0);
        check("after_timeout_done", {31'd0, load_done}, 32'd1);
        check("after_timeout_run", {31'd0, cpu_run}, 32'd1);
        check("after_timeout_err", {31'd0, load_err}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader for the tiny CPU: receives a framed byte stream, writes the instruction bytes into a 16 x 8 program memory, and gates the CPU with a run flag. The CPU fetches from this memory through an asynchronous read port. The loader is the writer side of the CPU's instruction memory. It sits between a byte source (UART RX or host bridge) and the CPU core.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1048576: maximum idle cycles between accepted bytes inside a frame. Used only with LOADER_TIMEOUT_EN.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  reset; asynchronous and active-low.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader can accept a byte.
- cpu_addr  input  4  CPU fetch address (its PC).
- cpu_instr  output  8  combinational read, mem[cpu_addr].
- cpu_run  output  1  CPU may execute. The CPU holds its PC at 0 while this is low.
- load_done  output  1  one-cycle pulse after a frame is accepted.
- load_err  output  1  sticky error flag.
- prog_len  output  5  length of the last good program, 1..16.

## Operation
- Frame format: 0xA5 sync byte, then LEN byte, then LEN instruction bytes, then CHK byte.
- CHK rule: (sum of instruction bytes + CHK) mod 256 == 0.
- A byte is accepted on an edge where in_valid && in_ready.
- in_ready is 1 in all states when not in reset.
- States and transitions:
  - SYNC:
    - 0xA5 accepted -> go to LEN, clear cpu_run, clear load_err.
    - Any other byte -> discarded, stay in SYNC.
  - LEN:
    - Byte in 1..16 -> latch N, clear idx and sum, go to DATA.
    - Byte 0 or greater than 16 -> set load_err, go to SYNC.
  - DATA, per accepted byte:
    - mem[idx] <= byte, sum <= sum + byte (8-bit wrap), idx <= idx + 1.
    - After the Nth byte -> go to CHK.
    - 0xA5 in DATA is ordinary data, not a resync.
  - CHK:
    - Checksum good -> cpu_run <= 1, prog_len <= N, load_done pulses, go to SYNC.
    - Checksum bad -> load_err <= 1, cpu_run stays 0, go to SYNC.
- Addresses N..15 keep their previous contents. The loader never clears memory.
- Memory is not reset. Contents after power-up are undefined until the first load.
- cpu_run stays 1 across stray non-sync bytes. Only a new 0xA5 halts the CPU.
- The CPU itself never writes to mem.

## Timing
- Reset values:
  - in_ready=0 while RST_N is low; 1 from the first edge after release.
  - cpu_run=0, load_done=0, load_err=0, prog_len=0.
  - State is SYNC; idx, sum and N are 0.
- Reset asserted mid-frame: the frame is abandoned. Bytes already written stay in mem, and cpu_run is 0.
- Write-to-read latency: a byte accepted at edge k is visible on cpu_instr from just after edge k, for a matching cpu_addr.
- cpu_run timing:
  - Falls at the edge that accepts the sync byte.
  - Rises at the edge that accepts a good CHK.
- load_done is high for exactly the one cycle following a good-CHK edge.
- Minimum frame is 4 accepted bytes for N=1. Back-to-back bytes, one per cycle, are supported.
- in_valid low stalls the FSM with no state change (see LOADER_TIMEOUT_EN).

## Configuration
- LOADER_TIMEOUT_EN defined:
  - A 21-bit idle counter runs in LEN, DATA and CHK.
  - The counter resets on every accepted byte and on entry to SYNC.
  - When it reaches TIMEOUT_CYCLES without an accepted byte: load_err <= 1, state <= SYNC, cpu_run stays 0.
- LOADER_TIMEOUT_EN undefined: no counter. The FSM waits indefinitely inside a frame.

## Test plan
- Good load: A5 03 11 22 33 CHK=0x9A, then read cpu_addr 0..2 -> 0x11,0x22,0x33. cpu_run=1, prog_len=3, load_done pulses once, load_err=0.
- Bad checksum: A5 02 10 20 CHK=0x00 -> load_err=1, cpu_run=0, no load_done. mem[0]=0x10 and mem[1]=0x20.
- Bad length: A5 00, then A5 11 -> load_err=1 each time, state returns to SYNC. A following good frame clears load_err and sets cpu_run=1.
- Data 0xA5 and halting a running CPU:
  - Good frame A5 02 A5 5B CHK=0x00 -> cpu_run=1, mem[0]=0xA5.
  - Stray 0x00 bytes -> cpu_run stays 1.
  - A new 0xA5 -> cpu_run=0 on that edge.
- Reset mid-frame: assert RST_N low after A5 04 11 -> all outputs at reset values immediately. After release, a good frame loads normally.
- Timeout (LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=16): A5 02 11, then in_valid low for 16 cycles -> load_err=1 and SYNC. A subsequent frame is accepted.
